// File: rtl/fft16_sequencer_if.sv
// Bundle of all non-clock signals between the 16-point FFT sequencer, its
// sample source/sink and the external radix-4 butterfly.
interface fft16_sequencer_if #(
   parameter int unsigned DW = 17
);
   localparam int unsigned SW = 2 * DW;
   localparam int unsigned BW = 8 * DW;

   logic          in_valid;
   logic          in_ready;
   logic [SW-1:0] in_data;
   logic [BW-1:0] bf_calc_in;
   logic [2:0]    bf_rotation;
   logic [BW-1:0] bf_calc_out;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] out_data;
   logic [3:0]    out_index;
   logic          busy;
   logic          frame_done;

   modport master (
      input  in_valid, in_data, bf_calc_out, out_ready,
      output in_ready, bf_calc_in, bf_rotation, out_valid, out_data,
             out_index, busy, frame_done
   );

   modport slave (
      output in_valid, in_data, bf_calc_out, out_ready,
      input  in_ready, bf_calc_in, bf_rotation, out_valid, out_data,
             out_index, busy, frame_done
   );
endinterface

// File: rtl/fft16_sequencer.sv
// Loads 16 complex samples, runs them twice through the external radix-4
// butterfly (4 column groups, then 4 row groups) and streams X[0..15] out.
module fft16_sequencer #(
   parameter int unsigned DW = 17
) (
   input  logic               clk,
   input  logic               rst,
   fft16_sequencer_if.master  bus
);
   localparam int unsigned SW = 2 * DW;
   localparam int unsigned BW = 8 * DW;
   localparam int unsigned NS = 16;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      S1   = 2'd1,
      S2   = 2'd2,
      OUT  = 2'd3
   } state_e;

   state_e        state_q;
   logic [3:0]    cnt_q;
   logic [1:0]    step_q;
   logic          in_ready_q;
   logic          out_valid_q;
   logic          busy_q;
   logic          frame_done_q;
   logic [SW-1:0] out_data_q;
   logic [3:0]    out_index_q;

   logic [SW-1:0] x_q   [NS];
   logic [BW-1:0] tmp_q [4];
   logic [BW-1:0] res_q [4];

   logic [BW-1:0] bf_in_c;
   logic [2:0]    bf_rot_c;
   logic          in_fire;
   logic          out_fire;
   logic [3:0]    out_index_d;
   logic [SW-1:0] out_data_d;

   function automatic logic [SW-1:0] lane_of(input logic [BW-1:0] v, input logic [1:0] i);
      case (i)
         2'd0:    return v[SW-1:0];
         2'd1:    return v[2*SW-1:SW];
         2'd2:    return v[3*SW-1:2*SW];
         default: return v[4*SW-1:3*SW];
      endcase
   endfunction

   assign in_fire     = (state_q == LOAD) && bus.in_valid && in_ready_q;
   assign out_fire    = (state_q == OUT) && out_valid_q && bus.out_ready;
   assign out_index_d = out_index_q + 4'd1;
   // Bin n lives in res[n mod 4], lane n div 4.
   assign out_data_d  = lane_of(res_q[out_index_d[1:0]], out_index_d[3:2]);

   // Butterfly operand mux: columns x[g+4l] in S1, lane k of each tmp in S2.
   always_comb begin
      bf_in_c  = '0;
      bf_rot_c = 3'd0;
      case (state_q)
         S1: begin
            for (int l = 0; l < 4; l++) begin
               bf_in_c[l*SW +: SW] = x_q[{2'(l), step_q}];
            end
            bf_rot_c = {1'b0, step_q};
         end
         S2: begin
            for (int l = 0; l < 4; l++) begin
               bf_in_c[l*SW +: SW] = lane_of(tmp_q[l], step_q);
            end
            bf_rot_c = {1'b1, step_q};
         end
         default: begin
            bf_in_c  = '0;
            bf_rot_c = 3'd0;
         end
      endcase
   end

   // Sample and intermediate storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         x_q[cnt_q] <= bus.in_data;
      end
      if (state_q == S1) begin
         tmp_q[step_q] <= bus.bf_calc_out;
      end
      if (state_q == S2) begin
         res_q[step_q] <= bus.bf_calc_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= LOAD;
         cnt_q        <= 4'd0;
         step_q       <= 2'd0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         out_data_q   <= '0;
         out_index_q  <= 4'd0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            LOAD: begin
               if (in_fire) begin
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'd15) begin
                     state_q    <= S1;
                     cnt_q      <= 4'd0;
                     step_q     <= 2'd0;
                     in_ready_q <= 1'b0;
                     busy_q     <= 1'b1;
                  end
               end
            end
            S1: begin
               step_q <= step_q + 2'd1;
               if (step_q == 2'd3) begin
                  state_q <= S2;
               end
            end
            S2: begin
               step_q <= step_q + 2'd1;
               if (step_q == 2'd3) begin
                  state_q     <= OUT;
                  out_valid_q <= 1'b1;
                  out_index_q <= 4'd0;
                  out_data_q  <= lane_of(res_q[0], 2'd0);
               end
            end
            OUT: begin
               if (out_fire) begin
                  if (out_index_q == 4'd15) begin
                     state_q      <= LOAD;
                     out_valid_q  <= 1'b0;
                     frame_done_q <= 1'b1;
                     in_ready_q   <= 1'b1;
                     busy_q       <= 1'b0;
                     out_index_q  <= 4'd0;
                  end else begin
                     out_index_q <= out_index_d;
                     out_data_q  <= out_data_d;
                  end
               end
            end
            default: begin
               state_q <= LOAD;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.bf_calc_in  = bf_in_c;
   assign bus.bf_rotation = bf_rot_c;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.out_index   = out_index_q;
   assign bus.busy        = busy_q;
   assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_fft16_sequencer.sv
// Directed bench for fft16_sequencer with a behavioural radix-4 butterfly and
// a queue of expected output bins.
module tb_fft16_sequencer;
   localparam int unsigned DW = 17;
   localparam int unsigned SW = 2 * DW;
   localparam int unsigned BW = 8 * DW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fft16_sequencer_if #(.DW(DW)) bus ();
   fft16_sequencer #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus.master));

   int n_pass   = 0;
   int n_checks = 0;

   logic [SW-1:0] exp_q [$];
   logic [SW-1:0] xin [16];
   logic [SW-1:0] ramp_exp [16];

   // W16^e = cos - j sin, Q8
   int cos_t [10] = '{256, 237, 181, 98, 0, -98, -181, -237, -256, -237};
   int sin_t [10] = '{0, 98, 181, 237, 256, 237, 181, 98, 0, -98};

   // 4-point DFT, then twiddle W16^(rot*m) on output lane m for rot < 4
   function automatic logic [BW-1:0] bf_func(input logic [BW-1:0] v, input logic [2:0] rot);
      int re [4];
      int im [4];
      int yr, yi, tr, ti, e;
      logic [BW-1:0] r;
      r = '0;
      for (int l = 0; l < 4; l++) begin
         re[l] = int'($signed(v[l*SW+DW +: DW]));
         im[l] = int'($signed(v[l*SW +: DW]));
      end
      for (int m = 0; m < 4; m++) begin
         yr = 0;
         yi = 0;
         for (int l = 0; l < 4; l++) begin
            case ((l * m) % 4)
               0: begin yr += re[l]; yi += im[l]; end
               1: begin yr += im[l]; yi -= re[l]; end
               2: begin yr -= re[l]; yi -= im[l]; end
               default: begin yr -= im[l]; yi += re[l]; end
            endcase
         end
         if (rot < 3'd4) begin
            e  = int'(rot) * m;
            tr = (yr * cos_t[e] + yi * sin_t[e]) >>> 8;
            ti = (yi * cos_t[e] - yr * sin_t[e]) >>> 8;
         end else begin
            tr = yr;
            ti = yi;
         end
         r[m*SW+DW +: DW] = DW'(tr);
         r[m*SW +: DW]    = DW'(ti);
      end
      return r;
   endfunction

   assign bus.bf_calc_out = bf_func(bus.bf_calc_in, bus.bf_rotation);

   task automatic ref_fft(input logic [SW-1:0] xs [16], output logic [SW-1:0] xo [16]);
      logic [BW-1:0] t [4];
      logic [BW-1:0] v;
      logic [BW-1:0] r;
      for (int g = 0; g < 4; g++) begin
         v = '0;
         for (int l = 0; l < 4; l++) v[l*SW +: SW] = xs[g + 4*l];
         t[g] = bf_func(v, 3'(g));
      end
      for (int k = 0; k < 4; k++) begin
         v = '0;
         for (int g = 0; g < 4; g++) v[g*SW +: SW] = t[g][k*SW +: SW];
         r = bf_func(v, 3'(4 + k));
         for (int j = 0; j < 4; j++) xo[k + 4*j] = r[j*SW +: SW];
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Feed xin[]; then watch the compute phase until out_valid (or abort by reset).
   task automatic load_frame(input bit gaps, input bit probe, input bit hold, input int rst_at);
      int cyc;
      for (int i = 0; i < 16; i++) begin
         if (gaps) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = xin[i];
         if (i == 0) chk("in_ready_load", 64'(bus.in_ready), 64'd1);
         @(negedge clk);
      end
      bus.in_valid = hold;
      bus.in_data  = SW'({$urandom(), $urandom()});
      cyc = 1;
      while (bus.out_valid !== 1'b1 && cyc < 40) begin
         if (rst_at == cyc) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_rotation", 64'(bus.bf_rotation), 64'd0);
            return;
         end
         if (cyc <= 8) begin
            chk("rotation", 64'(bus.bf_rotation), 64'(cyc - 1));
            chk("busy_calc", 64'(bus.busy), 64'd1);
            chk("in_ready_calc", 64'(bus.in_ready), 64'd0);
         end
         if (probe && cyc == 2) begin
            chk("s1g1_lane0", 64'(bus.bf_calc_in[0*SW +: SW]), 64'(xin[1]));
            chk("s1g1_lane1", 64'(bus.bf_calc_in[1*SW +: SW]), 64'(xin[5]));
            chk("s1g1_lane2", 64'(bus.bf_calc_in[2*SW +: SW]), 64'(xin[9]));
            chk("s1g1_lane3", 64'(bus.bf_calc_in[3*SW +: SW]), 64'(xin[13]));
         end
         @(negedge clk);
         cyc++;
      end
      chk("latency", 64'(cyc), 64'd9);
   endtask

   // Drain 16 bins against the scoreboard, optionally stalling at one index.
   task automatic collect(input int stall_at, input int stall_len);
      int n;
      int guard;
      int stalls;
      n = 0;
      guard = 0;
      stalls = stall_len;
      while (n < 16 && guard < 100) begin
         chk("out_valid", 64'(bus.out_valid), 64'd1);
         chk("out_index", 64'(bus.out_index), 64'(n));
         chk("out_data", 64'(bus.out_data), 64'(exp_q[0]));
         chk("frame_done_early", 64'(bus.frame_done), 64'd0);
         chk("in_ready_out", 64'(bus.in_ready), 64'd0);
         if (n == stall_at && stalls > 0) begin
            bus.out_ready = 1'b0;
            stalls--;
         end else begin
            bus.out_ready = 1'b1;
            void'(exp_q.pop_front());
            n++;
         end
         @(negedge clk);
         guard++;
      end
      if (n < 16) chk("collect_timeout", 64'(n), 64'd16);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk("end_out_valid", 64'(bus.out_valid), 64'd0);
      chk("end_frame_done", 64'(bus.frame_done), 64'd1);
      chk("end_in_ready", 64'(bus.in_ready), 64'd1);
      chk("end_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      chk("frame_done_pulse", 64'(bus.frame_done), 64'd0);
   endtask

   task automatic set_impulse();
      for (int i = 0; i < 16; i++) xin[i] = '0;
      xin[0] = {17'h00100, 17'h00000};
   endtask

   task automatic set_ramp();
      for (int i = 0; i < 16; i++) xin[i] = {DW'(i << 8), 17'h00000};
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_out_data", 64'(bus.out_data), 64'd0);
      chk("reset_out_index", 64'(bus.out_index), 64'd0);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_frame_done", 64'(bus.frame_done), 64'd0);
      chk("reset_bf_calc_in", 64'(bus.bf_calc_in == '0), 64'd1);
      chk("reset_bf_rotation", 64'(bus.bf_rotation), 64'd0);
      @(negedge clk);

      // Impulse: every bin is 1.0
      set_impulse();
      for (int i = 0; i < 16; i++) exp_q.push_back({17'h00100, 17'h00000});
      load_frame(1'b0, 1'b0, 1'b0, 0);
      collect(-1, 0);

      // DC: X[0] = 16.0, all others zero
      for (int i = 0; i < 16; i++) xin[i] = {17'h00100, 17'h00000};
      exp_q.push_back({17'h01000, 17'h00000});
      for (int i = 1; i < 16; i++) exp_q.push_back('0);
      load_frame(1'b0, 1'b0, 1'b0, 0);
      collect(-1, 0);

      // Ramp with operand probing
      set_ramp();
      ref_fft(xin, ramp_exp);
      for (int i = 0; i < 16; i++) exp_q.push_back(ramp_exp[i]);
      load_frame(1'b0, 1'b1, 1'b0, 0);
      collect(-1, 0);

      // Backpressure at bin 5 with in_valid held high through OUT
      for (int i = 0; i < 16; i++) exp_q.push_back(ramp_exp[i]);
      load_frame(1'b0, 1'b0, 1'b1, 0);
      collect(5, 3);

      // Gapped input must match the gap-free ramp result
      for (int i = 0; i < 16; i++) exp_q.push_back(ramp_exp[i]);
      load_frame(1'b1, 1'b0, 1'b0, 0);
      collect(-1, 0);

      // Reset during S2 k=2, then a clean impulse frame
      set_impulse();
      load_frame(1'b0, 1'b0, 1'b0, 7);
      for (int i = 0; i < 16; i++) exp_q.push_back({17'h00100, 17'h00000});
      load_frame(1'b0, 1'b0, 1'b0, 0);
      collect(-1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/fft16_sequencer.md
Name: fft16_sequencer

Overview:
Control and buffering stage that sits around the combinational radix-4 butterfly in the 16-point FFT datapath.
- Collects 16 complex samples serially.
- Drives the butterfly through 4 stage-1 groups (rotation 0..3) and 4 stage-2 groups (rotation 4..7), capturing the intermediate and final results.
- Streams X[0]..X[15] out in natural order through a valid/ready handshake.

Parameters:
- DW, 17, width of one real or imaginary part: sign + 8 integer + 8 fraction bits, two's complement.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample; high only in LOAD.
- in_data  in  2*DW  complex sample {real, imag}; real in the upper DW bits.
- bf_calc_in  out  8*DW  butterfly operand {lane3, lane2, lane1, lane0}, 2*DW bits per lane, lane0 at the LSBs.
- bf_rotation  out  3  butterfly twiddle select.
- bf_calc_out  in  8*DW  butterfly result, same lane packing as bf_calc_in.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output sample.
- out_data  out  2*DW  X[out_index] as {real, imag}.
- out_index  out  4  frequency bin of out_data.
- busy  out  1  high in S1, S2 and OUT.
- frame_done  out  1  one-cycle pulse after the last output handshake.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, port rst.
- State machine: LOAD -> S1 -> S2 -> OUT -> LOAD. There is no idle state.
- State after reset:
  - State LOAD, sample counter 0.
  - in_ready=1, out_valid=0, out_data=0, out_index=0, busy=0, frame_done=0.
  - bf_calc_in=0, bf_rotation=0.
  - Sample, intermediate and result storage contents need not be cleared.
- LOAD:
  - When in_valid and in_ready are both high, write in_data to x[cnt] and increment cnt.
  - The 16th accepted sample moves the state to S1 on the next edge and clears cnt.
  - in_valid low simply stalls the load.
- S1, four cycles, g=0..3:
  - bf_calc_in = {x[g+12], x[g+8], x[g+4], x[g]}; bf_rotation = g.
  - Both are driven combinationally from state, g and storage.
  - At the end of each cycle, capture bf_calc_out into tmp[g] (8*DW bits).
  - After g=3, go to S2.
- S2, four cycles, k=0..3:
  - bf_calc_in = {tmp[3].lane k, tmp[2].lane k, tmp[1].lane k, tmp[0].lane k}; bf_rotation = 4+k.
  - Capture bf_calc_out into res[k]. Result lane j of res[k] is X[k+4j].
  - After k=3, go to OUT.
- bf_calc_in and bf_rotation are 0 in LOAD and OUT.
- Latency: the last input handshake at edge T gives S1 for cycles T+1..T+4, S2 for T+5..T+8, and out_valid=1 from cycle T+9.
- OUT:
  - out_valid=1; out_data = res[n mod 4].lane(n div 4), with out_index = n.
  - n advances only on an out_valid && out_ready edge.
  - out_ready low holds out_data and out_index stable.
  - The handshake at n=15 sends the state to LOAD. On that same edge out_valid drops and frame_done pulses for one cycle.
  - in_ready is 1 in the cycle after that edge. There is no overlap between frames.
- Arithmetic: none in this block. Values pass through bit-exact; overflow and scaling belong to the butterfly.
- Simultaneous events:
  - in_valid during S1, S2 or OUT is ignored, since in_ready=0.
  - rst has priority over every transition.
- Reset mid-operation (any state): on the next edge, return to the reset state. The partial frame is discarded and the next frame loads from x[0].
- busy: 1 in S1, S2 and OUT; 0 in LOAD.

Test Plan:
1. Impulse. Bench instantiates the real butterfly.
   - Stimulus: x[0]=real 0x00100 (1.0), all other real and imaginary parts 0; out_ready=1.
   - Required: 16 outputs with out_index 0..15, every out_data = {0x00100, 0x00000}; out_valid rises exactly 9 cycles after the 16th input handshake; frame_done pulses once.
2. DC input.
   - Stimulus: all 16 samples real=0x00100, imag=0.
   - Required: X[0] = {0x01000 (16.0), 0}; X[1]..X[15] = {0, 0}.
3. Rotation and lane check.
   - Stimulus: probe bf_rotation and bf_calc_in each cycle, with x[n] real = n<<8.
   - Required: bf_rotation sequence 0,1,2,3,4,5,6,7; in S1 g=1, bf_calc_in lane0=x[1], lane3=x[13].
4. Backpressure.
   - Stimulus: out_ready=0 for 3 cycles while out_index=5, and in_valid held high throughout OUT.
   - Required: out_data and out_index stay at 5; in_ready stays 0; no extra sample is stored; the output sequence resumes correctly.
5. Input gaps.
   - Stimulus: in_valid toggles every other cycle.
   - Required: exactly 16 samples are stored; the transform output matches the gap-free case.
6. Reset mid-S2.
   - Stimulus: assert rst for 1 cycle during S2 k=2.
   - Required: next cycle in_ready=1, out_valid=0, busy=0; a following impulse frame gives the scenario-1 result.
